// File: rtl/ws_strip_driver.sv
// ws_strip_driver: WS281x serial LED frame driver with pixel prefetch; define WS_BRIGHTNESS_EN for global brightness scaling.
module ws_strip_driver #(
  parameter int LEDNUM = 25,
  parameter int BPP    = 24,
  parameter int ADDR_W = 6,
  parameter int T0H    = 20,
  parameter int T1H    = 40,
  parameter int TBIT   = 62,
  parameter int TRESET = 15000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [BPP-1:0]    pix_data,
  input  logic [7:0]        brightness,
  output logic [ADDR_W-1:0] pix_addr,
  output logic              pix_rd,
  output logic              busy,
  output logic              done,
  output logic              dout
);
  localparam int PW = $clog2(TBIT + 1);
  localparam int BW = $clog2(BPP + 1);
  localparam int RW = $clog2(TRESET + 1);
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(LEDNUM - 1);
  typedef enum logic [2:0] {IDLE, FETCH, LOAD, SEND, LATCH} state_t;
  state_t state;
  logic [PW-1:0] per;
  logic [BW-1:0] bit_cnt;
  logic [RW-1:0] lat;
  logic [ADDR_W-1:0] idx;
  logic [BPP-1:0] sh, nbuf, pix_s;
  logic pf_more;
  generate
    if (!(T0H < T1H && T1H < TBIT && BPP % 8 == 0)) begin : g_bad_params
      $error("ws_strip_driver: need T0H < T1H < TBIT and BPP multiple of 8");
    end
  endgenerate
`ifdef WS_BRIGHTNESS_EN
  genvar g;
  for (g = 0; g < BPP / 8; g++) begin : g_scale
    assign pix_s[8*g+:8] = 8'((16'(pix_data[8*g+:8]) * (16'(brightness) + 16'd1)) >> 8);
  end
`else
  logic unused_brightness;
  assign unused_brightness = ^brightness;
  assign pix_s = pix_data;
`endif
  assign pf_more = (idx + ADDR_W'(1)) < LAST;
  function automatic logic hi(input logic b, input logic [PW-1:0] p);
    return p < (b ? PW'(T1H) : PW'(T0H));
  endfunction
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      dout     <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      pix_rd   <= 1'b0;
      pix_addr <= '0;
      per      <= '0;
      bit_cnt  <= '0;
      lat      <= '0;
      idx      <= '0;
      sh       <= '0;
      nbuf     <= '0;
    end else begin
      done   <= 1'b0;
      pix_rd <= 1'b0;
      case (state)
        IDLE: if (start && !done) begin
          state    <= FETCH;
          busy     <= 1'b1;
          idx      <= '0;
          pix_rd   <= 1'b1;
          pix_addr <= '0;
        end
        FETCH: state <= LOAD;
        LOAD: begin
          state   <= SEND;
          sh      <= pix_s;
          per     <= '0;
          bit_cnt <= '0;
          dout    <= hi(pix_s[BPP-1], '0);
          pix_rd  <= LAST != '0;
          if (LAST != '0) pix_addr <= ADDR_W'(1);
        end
        SEND: begin
          if (per == PW'(1) && bit_cnt == '0 && idx < LAST) nbuf <= pix_s;
          if (per != PW'(TBIT - 1)) begin
            per  <= per + PW'(1);
            dout <= hi(sh[BPP-1], per + PW'(1));
          end else if (bit_cnt != BW'(BPP - 1)) begin
            per     <= '0;
            bit_cnt <= bit_cnt + BW'(1);
            sh      <= {sh[BPP-2:0], 1'b0};
            dout    <= hi(sh[BPP-2], '0);
          end else if (idx != LAST) begin
            per     <= '0;
            bit_cnt <= '0;
            idx     <= idx + ADDR_W'(1);
            sh      <= nbuf;
            dout    <= hi(nbuf[BPP-1], '0);
            pix_rd  <= pf_more;
            if (pf_more) pix_addr <= idx + ADDR_W'(2);
          end else begin
            state <= LATCH;
            lat   <= '0;
            dout  <= 1'b0;
          end
        end
        LATCH: if (lat == RW'(TRESET - 1)) begin
          state <= IDLE;
          done  <= 1'b1;
          busy  <= 1'b0;
        end else lat <= lat + RW'(1);
        default: state <= IDLE;
      endcase
    end
  end
endmodule
